// File: rtl/mem_pkg.sv
// Shared encodings and lane-mask helper for the data memory controller
// and the load-extension datapath.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Byte lanes touched by an access; illegal sizes touch nothing.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_BYTE: mask = 4'b0001 << addr_lo;
      SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word lane of a 32-bit word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    result_o = '0;
    byte_sel = word_i[8*addr_lo_i +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: result_o = unsigned_i ? {24'h0, byte_sel}
                                     : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: result_o = unsigned_i ? {16'h0, half_sel}
                                     : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: result_o = word_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Clocked data memory with byte/half/word access, configurable read latency
// and a valid/ready request/response handshake. Accesses are serialised.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [31:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             req_err;
  logic [3:0]       wmask;
  logic [31:0]      wdata_rep;
  logic [31:0]      load_word;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign idx    = req_addr[IDX_W+1:2];

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH)) req_err = 1'b1;
  end

  // Store data is right-aligned on the bus; replicate it across lanes so the
  // mask alone picks which bytes land.
  always_comb begin
    wdata_rep = req_wdata;
    case (req_size)
      SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  assign wmask = lane_mask(req_size, req_addr[1:0]);

  // NOTE: the storage array has no reset; its contents survive rst_n, so
  // committed stores remain visible after a mid-operation reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  load_extend u_load_extend (
    .word_i     (mem_q[idx]),
    .addr_lo_i  (req_addr[1:0]),
    .size_i     (req_size),
    .unsigned_i (req_unsigned),
    .result_o   (load_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rdata_d = (req_write || req_err) ? 32'h0 : load_word;
          err_d   = req_err;
          cnt_d   = '0;
          state_d = (LATENCY > 1) ? ST_BUSY : ST_RESP;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) state_d = ST_RESP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: a LATENCY=1 and a LATENCY=3 controller share one
// request bus; a byte-array model predicts every response.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid_l1, valid_l3;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        ready_l1, ready_l3, rv_l1, rv_l3, err_l1, err_l3;
  logic [31:0] rdata_l1, rdata_l3;

  logic        cur_sel;
  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic [31:0] o_resp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m [2][128];

  data_mem_ctrl #(.DEPTH(32), .ADDR_W(32), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_l1), .req_ready(ready_l1),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_l1),
    .resp_ready(resp_ready), .resp_rdata(rdata_l1), .resp_err(err_l1)
  );

  data_mem_ctrl #(.DEPTH(32), .ADDR_W(32), .LATENCY(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_l3), .req_ready(ready_l3),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_l3),
    .resp_ready(resp_ready), .resp_rdata(rdata_l3), .resp_err(err_l3)
  );

  assign o_req_ready  = cur_sel ? ready_l3 : ready_l1;
  assign o_resp_valid = cur_sel ? rv_l3    : rv_l1;
  assign o_resp_rdata = cur_sel ? rdata_l3 : rdata_l1;
  assign o_resp_err   = cur_sel ? err_l3   : err_l1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (addr % 4) != 0) return 1'b1;
    if (addr / 4 >= 32) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input bit sel, input logic [1:0] sz,
                                             input bit uns, input logic [31:0] addr);
    int a;
    logic [31:0] v;
    a = int'(addr);
    case (sz)
      2'd0: begin
        v = 32'(m[sel][a]);
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = 32'(m[sel][a]) + 32'(m[sel][a+1]) * 256;
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = 32'(m[sel][a]) + 32'(m[sel][a+1]) * 256
                 + 32'(m[sel][a+2]) * 65536 + 32'(m[sel][a+3]) * 16777216;
    endcase
    return v;
  endfunction

  task automatic model_store(input bit sel, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd);
    int a;
    int n;
    logic [31:0] d;
    a = int'(addr);
    d = wd;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      m[sel][a+i] = d[7:0];
      d = d >> 8;
    end
  endtask

  task automatic access(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        input string tag);
    int lat;
    bit exp_e;
    logic [31:0] exp_d;
    exp_e = model_err(sz, addr);
    exp_d = (wr || exp_e) ? 32'h0 : model_load(sel, sz, uns, addr);
    @(negedge clk);
    cur_sel      = sel;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    if (sel) valid_l3 = 1'b1;
    else     valid_l1 = 1'b1;
    check({tag, "/ready_idle"}, 32'(o_req_ready), 32'd1);
    @(posedge clk);
    if (wr && !exp_e) model_store(sel, sz, addr, wd);
    @(negedge clk);
    valid_l1  = 1'b0;
    valid_l3  = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!o_resp_valid && lat < 20) begin
      check({tag, "/ready_busy"}, 32'(o_req_ready), 32'd0);
      check({tag, "/rdata_busy"}, o_resp_rdata, 32'h0);
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), sel ? 32'd3 : 32'd1);
    if (!o_resp_valid) return;
    repeat (hold) begin
      check({tag, "/hold_rdata"}, o_resp_rdata, exp_d);
      check({tag, "/hold_ready"}, 32'(o_req_ready), 32'd0);
      @(negedge clk);
    end
    check({tag, "/valid"}, 32'(o_resp_valid), 32'd1);
    check({tag, "/rdata"}, o_resp_rdata, exp_d);
    check({tag, "/err"}, 32'(o_resp_err), 32'(exp_e));
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "/valid_after"}, 32'(o_resp_valid), 32'd0);
    check({tag, "/ready_after"}, 32'(o_req_ready), 32'd1);
    check({tag, "/rdata_after"}, o_resp_rdata, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; valid_l1 = 1'b0; valid_l3 = 1'b0; req_write = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; cur_sel = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      cur_sel = s[0];
      #1;
      check("rst/req_ready", 32'(o_req_ready), 32'd1);
      check("rst/resp_valid", 32'(o_resp_valid), 32'd0);
      check("rst/rdata", o_resp_rdata, 32'h0);
      check("rst/err", 32'(o_resp_err), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 32; w++)
        access(s[0], 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, "init");

    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, "w_st");
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "w_ld");
    check("w_ld/model", model_load(1'b0, 2'd2, 1'b0, 32'h10), 32'hDEADBEEF);

    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0, "b_word");
    access(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF80, 0, "b_st");
    access(1'b0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 0, "b_lds");
    access(1'b0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 0, "b_ldu");
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "b_ldw");
    check("b_merge/model", model_load(1'b0, 2'd2, 1'b0, 32'h20), 32'h11228044);

    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h32, 32'h1234BEEF, 0, "h_st");
    access(1'b0, 1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 0, "h_lds");
    access(1'b0, 1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 0, "h_ldu");
    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h31, 32'h5555, 0, "h_mis_st");
    access(1'b0, 1'b0, 2'd1, 1'b0, 32'h31, 32'h0, 0, "h_mis_ld");
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0, "h_unchanged");

    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 0, "range_ld");
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h80, 32'hA5A5A5A5, 0, "range_st");
    access(1'b0, 1'b1, 2'd3, 1'b0, 32'h04, 32'hA5A5A5A5, 0, "illegal_st");
    access(1'b0, 1'b0, 2'd3, 1'b0, 32'h04, 32'h0, 0, "illegal_ld");
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 0, "no_write");
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h7C, 32'h0, 0, "last_word");

    access(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADF00D, 5, "l3_st");
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5, "l3_ld");

    @(negedge clk);
    cur_sel = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h8;
    req_wdata = 32'hCAFEF00D; valid_l3 = 1'b1;
    @(posedge clk);
    model_store(1'b1, 2'd2, 32'h8, 32'hCAFEF00D);
    @(negedge clk);
    valid_l3 = 1'b0;
    check("rst_mid/busy_ready", 32'(o_req_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid/req_ready", 32'(o_req_ready), 32'd1);
    check("rst_mid/resp_valid", 32'(o_resp_valid), 32'd0);
    check("rst_mid/rdata", o_resp_rdata, 32'h0);
    check("rst_mid/err", 32'(o_resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid/no_resp", 32'(o_resp_valid), 32'd0);
    end
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0, "rst_mid_ld");
    check("rst_mid/model", model_load(1'b1, 2'd2, 1'b0, 32'h8), 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = 32'($urandom_range(0, 'h9F));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
             1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
